// File: rtl/ccff_chain_loader.sv
// Writer end of the ccff_head -> ccff_tail configuration chain: serialises bitstream
// words onto the chain head, or probes the chain length by walking a single 1 to the tail.
module ccff_chain_loader #(
  parameter  int CHAIN_LEN = 64,
  parameter  int WORD_W    = 8,
  localparam int CNT_W     = $clog2(2*CHAIN_LEN+1)
) (
  input  logic              prog_clk,
  input  logic              prog_reset_n,
  input  logic              start_load,
  input  logic              start_probe,
  input  logic              in_valid,
  input  logic [WORD_W-1:0] in_data,
  output logic              in_ready,
  output logic              ccff_head,
  output logic              chain_clk_en,
  input  logic              ccff_tail,
  output logic              busy,
  output logic              done,
  output logic              error,
  output logic [CNT_W-1:0]  probe_len
);
  localparam int WB_W = (WORD_W > 1) ? $clog2(WORD_W) : 1;
  localparam logic [CNT_W-1:0] LEN_M1  = CNT_W'(CHAIN_LEN - 1);
  localparam logic [CNT_W-1:0] LEN     = CNT_W'(CHAIN_LEN);
  localparam logic [CNT_W-1:0] LEN_X2  = CNT_W'(2 * CHAIN_LEN);
  localparam logic [WB_W-1:0]  WB_LAST = WB_W'(WORD_W - 1);

  typedef enum logic [2:0] {
    IDLE, LOAD_WAIT, LOAD_SHIFT, FLUSH, INJECT, PROBE_WAIT, DONE
  } state_e;

  state_e             state_q;
  logic [WORD_W-1:0]  sh_q;
  logic [WB_W-1:0]    wb_q;
  logic [CNT_W-1:0]   cnt_q;
  logic               in_ready_q, head_q, en_q, busy_q, done_q, error_q;
  logic [CNT_W-1:0]   probe_len_q;

  always_ff @(posedge prog_clk) begin
    if (!prog_reset_n) begin
      state_q     <= IDLE;
      sh_q        <= '0;
      wb_q        <= '0;
      cnt_q       <= '0;
      in_ready_q  <= 1'b0;
      head_q      <= 1'b0;
      en_q        <= 1'b0;
      busy_q      <= 1'b0;
      done_q      <= 1'b0;
      error_q     <= 1'b0;
      probe_len_q <= '0;
    end else begin
      done_q <= 1'b0;
      case (state_q)
        IDLE: begin
          if (start_load) begin
            state_q    <= LOAD_WAIT;
            in_ready_q <= 1'b1;
            busy_q     <= 1'b1;
            error_q    <= 1'b0;
            cnt_q      <= '0;
          end else if (start_probe) begin
            state_q <= FLUSH;
            en_q    <= 1'b1;
            head_q  <= 1'b0;
            busy_q  <= 1'b1;
            error_q <= 1'b0;
            cnt_q   <= '0;
          end
        end
        LOAD_WAIT: begin
          if (in_valid) begin
            state_q    <= LOAD_SHIFT;
            in_ready_q <= 1'b0;
            en_q       <= 1'b1;
            head_q     <= in_data[WORD_W-1];
            sh_q       <= in_data << 1;
            wb_q       <= '0;
          end
        end
        LOAD_SHIFT: begin
          // cnt_q counts bits already on the wire before this cycle's edge
          if (cnt_q == LEN_M1) begin
            state_q <= DONE;
            en_q    <= 1'b0;
            done_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
            if (wb_q == WB_LAST) begin
              state_q    <= LOAD_WAIT;
              en_q       <= 1'b0;
              in_ready_q <= 1'b1;
            end else begin
              wb_q   <= wb_q + 1'b1;
              head_q <= sh_q[WORD_W-1];
              sh_q   <= sh_q << 1;
            end
          end
        end
        FLUSH: begin
          if (cnt_q == LEN_M1) begin
            state_q <= INJECT;
            head_q  <= 1'b1;
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        INJECT: begin
          state_q <= PROBE_WAIT;
          head_q  <= 1'b0;
          cnt_q   <= CNT_W'(1);
        end
        PROBE_WAIT: begin
          if (ccff_tail || cnt_q == LEN_X2) begin
            state_q     <= DONE;
            en_q        <= 1'b0;
            done_q      <= 1'b1;
            probe_len_q <= cnt_q;
            error_q     <= !ccff_tail || (cnt_q != LEN);
          end else begin
            cnt_q <= cnt_q + 1'b1;
          end
        end
        DONE: begin
          state_q <= IDLE;
          busy_q  <= 1'b0;
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign in_ready     = in_ready_q;
  assign ccff_head    = head_q;
  assign chain_clk_en = en_q;
  assign busy         = busy_q;
  assign done         = done_q;
  assign error        = error_q;
  assign probe_len    = probe_len_q;
endmodule
